nor_tree_pipe: RTL and testbench

- Parametrised, pipelined wide-NOR (zero-detect) macro; successor to the fixed 4-input NOR cells.
- Reduces WIDTH inputs through a RADIX-ary OR tree with one register level per tree level, then inverts the result to ZN.
- Adds valid tracking, a stall enable, and an optional sticky mode that holds ZN low until cleared.
- Used for wide zero/flag detection in MCU datapaths where a single-cycle NOR tree misses timing.

---
 rtl/nor_tree_pipe.sv | 122 ++++++++++++
 tb/tb_nor_tree_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nor_tree_pipe.sv
`timescale 1ns/1ps
// Pipelined wide NOR / zero detect: RADIX-ary OR tree, one register per tree level, inverted to ZN.
// Latency: L = max(1, ceil(log_RADIX(WIDTH))) cycles; one operand accepted per cycle.
// Backpressure: EN low freezes every data, valid and sticky register; CLR still clears the sticky flag.
module nor_tree_pipe #(
    parameter int WIDTH = 16,
    parameter int RADIX = 4
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             VLD_IN,
    input  logic [WIDTH-1:0] A,
    input  logic             STICKY,
    input  logic             CLR,
    output logic             ZN,
    output logic             VLD_OUT,
    output logic             ANY
);
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int tree_levels(input int w, input int r);
        int n;
        int l;
        n = w;
        l = 0;
        for (int i = 0; i < 32; i++) begin
            if (n > 1) begin
                n = ceil_div(n, r);
                l++;
            end
        end
        return (l < 1) ? 1 : l;
    endfunction

    localparam int L     = tree_levels(WIDTH, RADIX);
    localparam int NODES = ceil_div(WIDTH, RADIX);
    localparam int PADW  = NODES * RADIX;

    logic [NODES-1:0] data [L];
    logic [NODES-1:0] nxt  [L];
    logic [PADW-1:0]  src;
    logic [L-1:0]     vld;
    logic [L:0]       vchain;
    logic             stk;
    logic             set_stk;
    logic             r;

    assign vchain = {vld, VLD_IN};

    // Every level uses the same NODES-wide register; nodes beyond a level's real
    // count only ever see zero padding, so they stay 0 and the final OR is exact.
    always_comb begin
        src = '0;
        for (int k = 0; k < L; k++) begin
            nxt[k] = '0;
            src    = '0;
            if (k == 0)
                src[WIDTH-1:0] = A;
            else
                src[NODES-1:0] = data[(k > 0) ? k - 1 : 0];
            for (int j = 0; j < NODES; j++)
                nxt[k][j] = |src[j*RADIX +: RADIX];
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            for (int k = 0; k < L; k++)
                data[k] <= '0;
            vld <= '0;
        end else if (EN) begin
            for (int k = 0; k < L; k++) begin
                vld[k] <= vchain[k];
                if (vchain[k])
                    data[k] <= nxt[k];
            end
        end
    end

    assign set_stk = EN & vchain[L-1] & (|nxt[L-1]) & STICKY;

    // CLR wins over a simultaneous set and acts even while stalled.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN)
            stk <= 1'b0;
        else if (CLR)
            stk <= 1'b0;
        else if (set_stk)
            stk <= 1'b1;
    end

    assign r       = |data[L-1];
    assign ZN      = ~(r | (STICKY & stk));
    assign VLD_OUT = vld[L-1];
    assign ANY     = stk;

`ifndef FUNCTIONAL
    specify
        (CLK => ZN)      = (1.0, 1.0);
        (CLK => VLD_OUT) = (1.0, 1.0);
        (CLK => ANY)     = (1.0, 1.0);
        $setup(A, posedge CLK, 0.0);
        $hold(posedge CLK, A, 0.0);
        $setup(VLD_IN, posedge CLK, 0.0);
        $hold(posedge CLK, VLD_IN, 0.0);
        $setup(EN, posedge CLK, 0.0);
        $hold(posedge CLK, EN, 0.0);
        $setup(STICKY, posedge CLK, 0.0);
        $hold(posedge CLK, STICKY, 0.0);
        $setup(CLR, posedge CLK, 0.0);
        $hold(posedge CLK, CLR, 0.0);
    endspecify
`endif

endmodule

// File: tb/tb_nor_tree_pipe.sv
`timescale 1ns/1ps
// Four instances (16/4, 5/4, 3/4, 256/2) share control; each operand's reduction-OR is queued
// with the EN-advance count at which it must emerge, and a monitor checks ZN/VLD_OUT/ANY every cycle.
module tb_nor_tree_pipe;
    localparam int NI = 4;

    typedef struct packed {
        logic orv;
        int   done;
    } exp_t;

    logic           clk;
    logic           rn;
    logic           en;
    logic           vld_in;
    logic           sticky;
    logic           clr;
    logic [15:0]    a16;
    logic [4:0]     a5;
    logic [2:0]     a3;
    logic [255:0]   a256;
    logic [NI-1:0]  zn;
    logic [NI-1:0]  vo;
    logic [NI-1:0]  any;

    exp_t           sb [NI][$];
    logic [NI-1:0]  m_vld;
    logic [NI-1:0]  m_or;
    logic [NI-1:0]  m_stk;
    int             en_cnt   = 0;
    int             checks   = 0;
    int             failures = 0;

    nor_tree_pipe #(.WIDTH(16), .RADIX(4)) u_w16 (
        .CLK(clk), .RN(rn), .EN(en), .VLD_IN(vld_in), .A(a16), .STICKY(sticky),
        .CLR(clr), .ZN(zn[0]), .VLD_OUT(vo[0]), .ANY(any[0]));
    nor_tree_pipe #(.WIDTH(5), .RADIX(4)) u_w5 (
        .CLK(clk), .RN(rn), .EN(en), .VLD_IN(vld_in), .A(a5), .STICKY(sticky),
        .CLR(clr), .ZN(zn[1]), .VLD_OUT(vo[1]), .ANY(any[1]));
    nor_tree_pipe #(.WIDTH(3), .RADIX(4)) u_w3 (
        .CLK(clk), .RN(rn), .EN(en), .VLD_IN(vld_in), .A(a3), .STICKY(sticky),
        .CLR(clr), .ZN(zn[2]), .VLD_OUT(vo[2]), .ANY(any[2]));
    nor_tree_pipe #(.WIDTH(256), .RADIX(2)) u_w256 (
        .CLK(clk), .RN(rn), .EN(en), .VLD_IN(vld_in), .A(a256), .STICKY(sticky),
        .CLR(clr), .ZN(zn[3]), .VLD_OUT(vo[3]), .ANY(any[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int i);
        case (i)
            0:       return 2;
            1:       return 2;
            2:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic or_of(input int i, input logic [255:0] v);
        case (i)
            0:       return v[15:0] != 16'd0;
            1:       return v[4:0] != 5'd0;
            2:       return v[2:0] != 3'd0;
            default: return v != 256'd0;
        endcase
    endfunction

    function automatic logic [255:0] rnd_vec();
        logic [255:0] v;
        v = '0;
        case ($urandom_range(0, 4))
            0:       v = '0;
            1:       v[$urandom_range(0, 255)] = 1'b1;
            2:       v[$urandom_range(0, 15)] = 1'b1;
            3:       for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
            default: v = '1;
        endcase
        return v;
    endfunction

    task automatic check(input string nm, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t actual=%b expected=%b", nm, i, $time, act, exp);
        end
    endtask

    // One cycle of stimulus, driven on the falling edge; accepted operands enter the scoreboard.
    task automatic cyc(input logic e, input logic v, input logic s, input logic c,
                       input logic [255:0] a);
        exp_t ent;
        @(negedge clk);
        en     = e;
        vld_in = v;
        sticky = s;
        clr    = c;
        a16    = a[15:0];
        a5     = a[4:0];
        a3     = a[2:0];
        a256   = a;
        if (e && v && rn) begin
            for (int i = 0; i < NI; i++) begin
                ent.orv  = or_of(i, a);
                ent.done = en_cnt + lat(i) - 1;
                sb[i].push_back(ent);
            end
        end
    endtask

    initial begin : monitor
        int   this_e;
        logic done_now;
        logic en_s;
        logic clr_s;
        logic st_s;
        forever begin
            @(posedge clk or negedge rn);
            if (!rn) begin
                for (int i = 0; i < NI; i++)
                    sb[i].delete();
                m_vld = '0;
                m_or  = '0;
                m_stk = '0;
            end else begin
                en_s   = en;
                clr_s  = clr;
                st_s   = sticky;
                this_e = en_cnt;
                if (en_s)
                    en_cnt++;
                for (int i = 0; i < NI; i++) begin
                    done_now = 1'b0;
                    if (en_s) begin
                        if (sb[i].size() > 0 && sb[i][0].done == this_e) begin
                            done_now = 1'b1;
                            m_or[i]  = sb[i][0].orv;
                            void'(sb[i].pop_front());
                        end
                        m_vld[i] = done_now;
                    end
                    if (clr_s)
                        m_stk[i] = 1'b0;
                    else if (done_now && m_or[i] && st_s)
                        m_stk[i] = 1'b1;
                end
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                check("zn", i, zn[i], ~(m_or[i] | (sticky & m_stk[i])));
                check("vld_out", i, vo[i], m_vld[i]);
                check("any", i, any[i], m_stk[i]);
            end
        end
    end

    initial begin : stimulus
        logic [255:0] one;
        rn = 1'b0; en = 1'b0; vld_in = 1'b0; sticky = 1'b0; clr = 1'b0;
        a16 = '0; a5 = '0; a3 = '0; a256 = '0;

        // Held in reset with live inputs, then release with no operand.
        repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0, rnd_vec());
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        rn = 1'b1;
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, rnd_vec());

        // Back-to-back latency/throughput.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 256'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 256'h100);
        repeat (9) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Stall for three cycles right after launch.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 256'h8000);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd_vec());
        repeat (9) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Sticky set, hold through zero results, clear, then clear coinciding with a set.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 256'h4);
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 256'h0);
        repeat (8) cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 256'h10);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, '0);
        repeat (9) cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Padding: only bit 4 set, then all zero.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 256'h10);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 256'h0);

        // Walking one across all 256 positions.
        for (int i = 0; i < 256; i++) begin
            one = 256'd1 << i;
            cyc(1'b1, 1'b1, 1'b0, 1'b0, one);
        end
        repeat (9) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset between edges with a full pipeline and sticky set.
        repeat (9) cyc(1'b1, 1'b1, 1'b1, 1'b0, '1);
        @(negedge clk);
        en = 1'b1; vld_in = 1'b0; clr = 1'b0;
        #2 rn = 1'b0;
        #2 rn = 1'b1;
        repeat (10) cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);

        // Random traffic.
        for (int n = 0; n < 500; n++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, rnd_vec());
        repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
